// File: rtl/obstacle_spawner_multi.sv
// Obstacle slots that scroll left by `speed` on each running frame tick.
// A new obstacle spawns once the previously spawned one has crossed GEN_LINE.
module obstacle_spawner_multi #(
   parameter int NUM_SLOTS = 4,
   parameter int POS_W     = 9,
   parameter int TYPE_W    = 3,
   parameter int JIT_W     = 5,
   parameter int GEN_LINE  = 250,
   parameter int SPEED_W   = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          tick,
   input  logic                          run,
   input  logic                          clear,
   input  logic [SPEED_W-1:0]            speed,
   input  logic [TYPE_W+JIT_W-1:0]       rng,
   output logic [NUM_SLOTS*POS_W-1:0]    obs_pos,
   output logic [NUM_SLOTS*TYPE_W-1:0]   obs_type,
   output logic [NUM_SLOTS-1:0]          obs_active,
   output logic                          spawn_pulse,
   output logic [$clog2(NUM_SLOTS)-1:0]  spawn_slot
);

   localparam int IDX_W = $clog2(NUM_SLOTS);
   localparam int RNG_W = TYPE_W + JIT_W;

   logic [POS_W-1:0]  pos_q  [NUM_SLOTS];
   logic [POS_W-1:0]  pos_d  [NUM_SLOTS];
   logic [TYPE_W-1:0] type_q [NUM_SLOTS];
   logic [TYPE_W-1:0] type_d [NUM_SLOTS];
   logic              gen_ok_q, gen_ok_d;
   logic [IDX_W-1:0]  last_idx_q, last_idx_d;
   logic [IDX_W-1:0]  spawn_slot_q, spawn_slot_d;
   logic              spawn_pulse_q, spawn_pulse_d;

   logic              free_found;
   logic [IDX_W-1:0]  free_idx;
   logic [POS_W-1:0]  speed_ext;
   logic [POS_W-1:0]  spawn_pos;

   assign speed_ext = {{(POS_W-SPEED_W){1'b0}}, speed};
   assign spawn_pos = {{(POS_W-JIT_W){1'b1}}, rng[JIT_W-1:0]};

   // Free slot search uses pre-update positions, so a slot emptied this tick waits a tick.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!free_found && pos_q[i] == '0) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      pos_d         = pos_q;
      type_d        = type_q;
      gen_ok_d      = gen_ok_q;
      last_idx_d    = last_idx_q;
      spawn_slot_d  = spawn_slot_q;
      spawn_pulse_d = 1'b0;
      if (clear) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            pos_d[i]  = '0;
            type_d[i] = '0;
         end
         gen_ok_d     = 1'b1;
         last_idx_d   = '0;
         spawn_slot_d = '0;
      end else if (tick && run) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (pos_q[i] != '0) begin
               pos_d[i] = (pos_q[i] > speed_ext) ? pos_q[i] - speed_ext : '0;
            end
         end
         if (gen_ok_q && free_found) begin
            pos_d[free_idx]  = spawn_pos;
            type_d[free_idx] = rng[RNG_W-1:JIT_W];
            last_idx_d       = free_idx;
            gen_ok_d         = 1'b0;
            spawn_slot_d     = free_idx;
            spawn_pulse_d    = 1'b1;
         end else if (pos_q[last_idx_q] <= POS_W'(GEN_LINE)) begin
            // <= so that a fast obstacle jumping over the line still opens the gate
            gen_ok_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            pos_q[i]  <= '0;
            type_q[i] <= '0;
         end
         gen_ok_q      <= 1'b1;
         last_idx_q    <= '0;
         spawn_slot_q  <= '0;
         spawn_pulse_q <= 1'b0;
      end else begin
         pos_q         <= pos_d;
         type_q        <= type_d;
         gen_ok_q      <= gen_ok_d;
         last_idx_q    <= last_idx_d;
         spawn_slot_q  <= spawn_slot_d;
         spawn_pulse_q <= spawn_pulse_d;
      end
   end

   always_comb begin
      obs_pos    = '0;
      obs_type   = '0;
      obs_active = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         obs_pos[i*POS_W +: POS_W]    = pos_q[i];
         obs_type[i*TYPE_W +: TYPE_W] = type_q[i];
         obs_active[i]                = (pos_q[i] != '0);
      end
   end

   assign spawn_pulse = spawn_pulse_q;
   assign spawn_slot  = spawn_slot_q;

endmodule

// File: tb/tb_obstacle_spawner_multi.sv
// Bench for obstacle_spawner_multi: two instances (gate lines 250 and 500) driven
// identically and checked every cycle against a slot-list model, plus fixed scenarios.
module tb_obstacle_spawner_multi;

   localparam int N  = 4;
   localparam int PW = 9;
   localparam int TW = 3;

   logic          clk = 1'b0;
   logic          rst_n, tick, run, clear;
   logic [2:0]    speed;
   logic [7:0]    rng;

   logic [N*PW-1:0] a_obs_pos, b_obs_pos;
   logic [N*TW-1:0] a_obs_type, b_obs_type;
   logic [N-1:0]    a_obs_active, b_obs_active;
   logic            a_spawn_pulse, b_spawn_pulse;
   logic [1:0]      a_spawn_slot, b_spawn_slot;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // model state, index 0 = gate line 250, index 1 = gate line 500
   int m_pos  [2][N];
   int m_type [2][N];
   int m_gen  [2];
   int m_last [2];
   int m_slot [2];
   int m_pulse[2];

   obstacle_spawner_multi #(.NUM_SLOTS(N), .POS_W(PW), .TYPE_W(TW), .JIT_W(5),
                            .GEN_LINE(250), .SPEED_W(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .clear(clear),
      .speed(speed), .rng(rng), .obs_pos(a_obs_pos), .obs_type(a_obs_type),
      .obs_active(a_obs_active), .spawn_pulse(a_spawn_pulse), .spawn_slot(a_spawn_slot));

   obstacle_spawner_multi #(.NUM_SLOTS(N), .POS_W(PW), .TYPE_W(TW), .JIT_W(5),
                            .GEN_LINE(500), .SPEED_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .clear(clear),
      .speed(speed), .rng(rng), .obs_pos(b_obs_pos), .obs_type(b_obs_type),
      .obs_active(b_obs_active), .spawn_pulse(b_spawn_pulse), .spawn_slot(b_spawn_slot));

   // clock / reset block
   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: list of slots, every live one slides by speed, first hole gets a new obstacle.
   task automatic model_step(int k, int gl);
      int np[N];
      int fr;
      if (!rst_n || clear) begin
         for (int i = 0; i < N; i++) begin
            m_pos[k][i]  = 0;
            m_type[k][i] = 0;
         end
         m_gen[k] = 1; m_last[k] = 0; m_slot[k] = 0; m_pulse[k] = 0;
      end else if (tick && run) begin
         m_pulse[k] = 0;
         fr = -1;
         for (int i = 0; i < N; i++) if (fr < 0 && m_pos[k][i] == 0) fr = i;
         for (int i = 0; i < N; i++)
            np[i] = (m_pos[k][i] > int'(speed)) ? m_pos[k][i] - int'(speed) : 0;
         if (m_gen[k] == 1 && fr >= 0) begin
            np[fr]        = 480 + (int'(rng) % 32);
            m_type[k][fr] = int'(rng) / 32;
            m_last[k]     = fr;
            m_slot[k]     = fr;
            m_gen[k]      = 0;
            m_pulse[k]    = 1;
         end else if (m_pos[k][m_last[k]] <= gl) begin
            m_gen[k] = 1;
         end
         for (int i = 0; i < N; i++) m_pos[k][i] = np[i];
      end else begin
         m_pulse[k] = 0;
      end
   endtask

   always @(posedge clk) begin
      model_step(0, 250);
      model_step(1, 500);
   end

   task automatic cmp(int k, logic [N*PW-1:0] p, logic [N*TW-1:0] t, logic [N-1:0] a,
                      logic pl, logic [1:0] s);
      logic [N*PW-1:0] ep;
      logic [N*TW-1:0] et;
      logic [N-1:0]    ea;
      for (int i = 0; i < N; i++) begin
         ep[i*PW +: PW] = PW'(m_pos[k][i]);
         et[i*TW +: TW] = TW'(m_type[k][i]);
         ea[i]          = (m_pos[k][i] != 0);
      end
      chk($sformatf("dut%0d obs_pos", k), 64'(p), 64'(ep));
      chk($sformatf("dut%0d obs_type", k), 64'(t), 64'(et));
      chk($sformatf("dut%0d obs_active", k), 64'(a), 64'(ea));
      chk($sformatf("dut%0d spawn_pulse", k), 64'(pl), 64'(m_pulse[k]));
      chk($sformatf("dut%0d spawn_slot", k), 64'(s), 64'(m_slot[k]));
   endtask

   // scoreboard compare, once per cycle away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, a_obs_pos, a_obs_type, a_obs_active, a_spawn_pulse, a_spawn_slot);
         cmp(1, b_obs_pos, b_obs_type, b_obs_active, b_spawn_pulse, b_spawn_slot);
      end
   end

   // driver: apply inputs, let one active edge and the compare pass, return just after
   task automatic step(bit r, bit t, bit rn, bit c, logic [2:0] sp, logic [7:0] rv);
      rst_n = r; tick = t; run = rn; clear = c; speed = sp; rng = rv;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 8'h00);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00);
   endtask

   function automatic int apos(int i);
      return int'(a_obs_pos[i*PW +: PW]);
   endfunction

   initial begin
      int n;
      rst_n = 1'b0; tick = 1'b0; run = 1'b0; clear = 1'b0; speed = '0; rng = '0;
      @(negedge clk); #1;
      do_reset();
      chk_en = 1'b1;
      do_reset();
      chk("reset obs_pos", 64'(a_obs_pos), 64'd0);
      chk("reset obs_active", 64'(a_obs_active), 64'd0);
      chk("reset spawn_pulse", 64'(a_spawn_pulse), 64'd0);
      chk("reset spawn_slot", 64'(a_spawn_slot), 64'd0);

      // first tick after reset spawns into slot 0
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 8'hA5);
      chk("t1 pos0", 64'(apos(0)), 64'd485);
      chk("t1 type0", 64'(a_obs_type[2:0]), 64'd5);
      chk("t1 active", 64'(a_obs_active), 64'b0001);
      chk("t1 pulse", 64'(a_spawn_pulse), 64'd1);
      chk("t1 slot", 64'(a_spawn_slot), 64'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'hA5);
      chk("t1 pulse drops", 64'(a_spawn_pulse), 64'd0);

      // speed 1: gate opens on the tick with pre-pos 250, spawn on the next one
      n = 0;
      do begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 8'($urandom));
         n++;
      end while (!a_spawn_pulse && n < 300);
      chk("t2 ticks to spawn", 64'(n), 64'd237);
      chk("t2 slot", 64'(a_spawn_slot), 64'd1);
      chk("t2 pos0", 64'(apos(0)), 64'd248);

      // speed 7 jumps 253 -> 246 without missing the line
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 8'h04);
      chk("t6 pos0", 64'(apos(0)), 64'd484);
      n = 0;
      do begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 8'($urandom));
         n++;
      end while (!a_spawn_pulse && n < 100);
      chk("t6 ticks to spawn", 64'(n), 64'd36);
      chk("t6 slot", 64'(a_spawn_slot), 64'd1);
      chk("t6 pos0", 64'(apos(0)), 64'd232);

      // saturate at zero, no wrap, no reuse in the same tick
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 8'hA5);
      n = 0;
      while (m_pos[0][0] != 2 && n < 100) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 8'($urandom));
         n++;
      end
      chk("t3 reached 2", 64'(n), 64'd69);
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 8'h3C);
      chk("t3 pos0 zero", 64'(apos(0)), 64'd0);
      chk("t3 active0", 64'(a_obs_active[0]), 64'd0);
      chk("t3 no reuse", 64'(a_spawn_pulse && a_spawn_slot == 2'd0), 64'd0);

      // freeze, then clear with a tick
      for (int i = 0; i < 10; i++)
         step(1'b1, 1'b1, 1'b0, 1'b0, 3'($urandom), 8'($urandom));
      chk("t4 frozen pulse", 64'(a_spawn_pulse), 64'd0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 8'hFF);
      chk("t4 clear pos", 64'(a_obs_pos), 64'd0);
      chk("t4 clear active b", 64'(b_obs_active), 64'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 8'h2A);
      chk("t4 respawn slot", 64'(a_spawn_slot), 64'd0);
      chk("t4 respawn pos0", 64'(apos(0)), 64'd490);
      chk("t4 respawn pulse", 64'(a_spawn_pulse), 64'd1);

      // gate line 500: fill all slots, deferred spawn while all are busy
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
      chk("t5 all busy pos", 64'(b_obs_pos), 64'({4{9'd480}}));
      chk("t5 no pulse", 64'(b_spawn_pulse), 64'd0);
      chk("t5 slot", 64'(b_spawn_slot), 64'd3);
      n = 0;
      do begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 8'h00);
         n++;
      end while (!b_spawn_pulse && n < 100);
      chk("t5 deferred ticks", 64'(n), 64'd70);
      chk("t5 deferred slot", 64'(b_spawn_slot), 64'd0);

      // randomized traffic
      for (int i = 0; i < 4000; i++)
         step(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0),
              3'($urandom), 8'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
